// File: rtl/hyperbus_target_mem.sv
// HyperBus device-side responder: command/address decode, initial latency,
// linear/wrapped bursts over a flop-based word array, plus ID0/CR0 registers.
// One CK period of the bus is presented per ck_en_i pulse as a 16-bit word.
module hyperbus_target_mem #(
  parameter int unsigned AddrWidth     = 10,
  parameter int unsigned Latency       = 6,
  parameter int unsigned DoubleLatency = 1,
  parameter int unsigned WrapWords     = 16,
  parameter logic [15:0] IdValue       = 16'h0C81
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cs_ni,
  input  logic        ck_en_i,
  input  logic [15:0] dq_i,
  output logic [15:0] dq_o,
  output logic        dq_oe_o,
  input  logic [1:0]  rwds_i,
  output logic [1:0]  rwds_o,
  output logic        rwds_oe_o
);

  localparam int unsigned WrapBits = $clog2(WrapWords);
  localparam int unsigned Depth    = 2 ** AddrWidth;
  localparam logic [15:0] Cr0Reset = {8'h00, 4'(Latency), 1'(DoubleLatency), 3'b000};

  typedef enum logic [1:0] {StIdle, StCa, StLat, StData} state_e;

  state_e               state_q, state_d;
  logic [1:0]           ca_cnt_q, ca_cnt_d;
  logic [31:0]          ca_q, ca_d;        // first two CA words
  logic                 rd_q, rd_d;        // R/W#
  logic                 as_q, as_d;        // register space
  logic                 lin_q, lin_d;      // linear burst
  logic                 rsel_q, rsel_d;    // 1 = CR0, 0 = ID0
  logic [4:0]           lat_q, lat_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [15:0]          cr0_q, cr0_d;
  logic                 mem_we;

  logic [15:0] mem_q [Depth];

  logic [47:0]          ca_full;
  logic [31:0]          ca_waddr;
  logic [3:0]           lat_base;
  logic [4:0]           lat_total;
  logic [AddrWidth-1:0] addr_lin, addr_wrap;
  logic [15:0]          rd_data;
  logic                 unused_ca;

  assign ca_full   = {ca_q, dq_i};
  assign ca_waddr  = {ca_full[44:16], ca_full[2:0]};
  assign unused_ca = ^{ca_waddr[31:AddrWidth], ca_full[15:3]};

  // Latency is frozen from CR0 when the command completes, so a CR0 write
  // only ever affects later transactions.
  assign lat_base  = (cr0_q[7:4] < 4'd3) ? 4'd3 : cr0_q[7:4];
  assign lat_total = cr0_q[3] ? {lat_base, 1'b0} : {1'b0, lat_base};

  assign addr_lin  = addr_q + AddrWidth'(1);
  assign addr_wrap = {addr_q[AddrWidth-1:WrapBits], addr_q[WrapBits-1:0] + WrapBits'(1)};

  assign rd_data = as_q ? (rsel_q ? cr0_q : IdValue) : mem_q[addr_q];

  // Next-state logic: command capture, latency count, data-phase addressing.
  always_comb begin
    state_d  = state_q;
    ca_cnt_d = ca_cnt_q;
    ca_d     = ca_q;
    rd_d     = rd_q;
    as_d     = as_q;
    lin_d    = lin_q;
    rsel_d   = rsel_q;
    lat_d    = lat_q;
    addr_d   = addr_q;
    cr0_d    = cr0_q;
    mem_we   = 1'b0;
    if (cs_ni) begin
      state_d  = StIdle;
      ca_cnt_d = 2'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d  = StCa;
          ca_cnt_d = 2'd0;
        end
        StCa: begin
          if (ck_en_i) begin
            ca_d     = {ca_q[15:0], dq_i};
            ca_cnt_d = ca_cnt_q + 2'd1;
            if (ca_cnt_q == 2'd2) begin
              rd_d    = ca_full[47];
              as_d    = ca_full[46];
              lin_d   = ca_full[45];
              rsel_d  = ca_full[16];
              addr_d  = ca_waddr[AddrWidth-1:0];
              lat_d   = lat_total;
              // Register writes carry no initial latency.
              state_d = (ca_full[46] && !ca_full[47]) ? StData : StLat;
            end
          end
        end
        StLat: begin
          if (ck_en_i) begin
            if (lat_q <= 5'd1) state_d = StData;
            else               lat_d   = lat_q - 5'd1;
          end
        end
        StData: begin
          if (ck_en_i) begin
            if (as_q) begin
              if (!rd_q && rsel_q) cr0_d = dq_i;
            end else begin
              mem_we = !rd_q;
              addr_d = lin_q ? addr_lin : addr_wrap;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      ca_cnt_q <= 2'd0;
      ca_q     <= '0;
      rd_q     <= 1'b0;
      as_q     <= 1'b0;
      lin_q    <= 1'b0;
      rsel_q   <= 1'b0;
      lat_q    <= '0;
      addr_q   <= '0;
      cr0_q    <= Cr0Reset;
    end else begin
      state_q  <= state_d;
      ca_cnt_q <= ca_cnt_d;
      ca_q     <= ca_d;
      rd_q     <= rd_d;
      as_q     <= as_d;
      lin_q    <= lin_d;
      rsel_q   <= rsel_d;
      lat_q    <= lat_d;
      addr_q   <= addr_d;
      cr0_q    <= cr0_d;
    end
  end

  // Word array with per-byte write masking; contents are not reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      if (!rwds_i[1]) mem_q[addr_q][15:8] <= dq_i[15:8];
      if (!rwds_i[0]) mem_q[addr_q][7:0]  <= dq_i[7:0];
    end
  end

  // Pad outputs decoded from the current state only, so they hold across
  // cycles without ck_en_i.
  always_comb begin
    dq_o      = 16'h0000;
    dq_oe_o   = 1'b0;
    rwds_o    = 2'b00;
    rwds_oe_o = 1'b0;
    unique case (state_q)
      StIdle: ;
      StCa: begin
        rwds_oe_o = 1'b1;
        rwds_o    = {2{cr0_q[3]}};
      end
      StLat: rwds_oe_o = rd_q;
      StData: begin
        if (rd_q) begin
          dq_o      = rd_data;
          dq_oe_o   = 1'b1;
          rwds_oe_o = 1'b1;
          rwds_o    = 2'b10;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hyperbus_target_mem.sv
// Randomised bench for hyperbus_target_mem against a word-level memory/register model.
module tb_hyperbus_target_mem;

  localparam int N  = 1024;
  localparam int WW = 16;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        cs_ni;
  logic        ck_en_i;
  logic [15:0] dq_i;
  logic [15:0] dq_o;
  logic        dq_oe_o;
  logic [1:0]  rwds_i;
  logic [1:0]  rwds_o;
  logic        rwds_oe_o;

  always #5 clk = ~clk;

  hyperbus_target_mem dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .cs_ni    (cs_ni),
    .ck_en_i  (ck_en_i),
    .dq_i     (dq_i),
    .dq_o     (dq_o),
    .dq_oe_o  (dq_oe_o),
    .rwds_i   (rwds_i),
    .rwds_o   (rwds_o),
    .rwds_oe_o(rwds_oe_o)
  );

  int n_err = 0;
  int n_chk = 0;
  int max_gap = 2;

  logic [15:0] mem_m [N];
  logic [15:0] cr0_m;
  logic [15:0] wq [$];
  logic [1:0]  mq [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clk cycle: drive away from the edge, return just after it.
  task automatic step(input logic cs, input logic ce, input logic [15:0] dq, input logic [1:0] rw);
    @(negedge clk);
    cs_ni = cs; ck_en_i = ce; dq_i = dq; rwds_i = rw;
    @(posedge clk);
    #1;
  endtask

  task automatic gaps();
    int g;
    g = (max_gap == 0) ? 0 : int'($urandom_range(max_gap, 0));
    repeat (g) step(1'b0, 1'b0, 16'($urandom), 2'($urandom));
  endtask

  function automatic int lat_of(input logic [15:0] c);
    int b;
    b = (c[7:4] < 4'd3) ? 3 : int'(c[7:4]);
    return c[3] ? 2 * b : b;
  endfunction

  function automatic int nxt(input int a, input bit lin);
    if (lin) return (a + 1) % N;
    return (a & ~(WW - 1)) | ((a + 1) & (WW - 1));
  endfunction

  // addr: word address (register space: 0 = ID0, 8 = CR0).
  // ca_abort < 3 raises cs_ni after that many CA words.
  task automatic xfer(input bit rd, input bit as, input bit lin, input int addr, input int n,
                      input int ca_abort);
    logic [31:0] ua;
    logic [47:0] ca;
    logic [15:0] w, exp;
    logic [1:0]  m;
    int a, lt;
    ua = 32'(addr);
    ca = {rd, as, lin, ua[31:3], 13'd0, ua[2:0]};
    step(1'b0, 1'b0, 16'($urandom), 2'b00);
    for (int i = 0; i < 3; i++) begin
      if (i == ca_abort) begin
        step(1'b1, 1'b0, 16'($urandom), 2'b00);
        check_eq("abort_rwds_oe", 32'(rwds_oe_o), 32'd0);
        return;
      end
      gaps();
      step(1'b0, 1'b1, ca[47-16*i -: 16], 2'($urandom));
      if (i < 2) begin
        check_eq("ca_rwds_oe", 32'(rwds_oe_o), 32'd1);
        check_eq("ca_rwds", 32'(rwds_o), 32'({2{cr0_m[3]}}));
      end
    end
    lt = (as && !rd) ? 0 : lat_of(cr0_m);
    for (int j = 0; j < lt; j++) begin
      check_eq("lat_dq_oe", 32'(dq_oe_o), 32'd0);
      check_eq("lat_rwds_oe", 32'(rwds_oe_o), 32'(rd));
      if (rd) check_eq("lat_rwds", 32'(rwds_o), 32'd0);
      gaps();
      step(1'b0, 1'b1, 16'($urandom), 2'($urandom));
    end
    a = addr % N;
    for (int k = 0; k < n; k++) begin
      gaps();
      if (rd) begin
        if (as) exp = ua[3] ? cr0_m : 16'h0C81;
        else    exp = mem_m[a];
        check_eq("rd_dq", 32'(dq_o), 32'(exp));
        check_eq("rd_dq_oe", 32'(dq_oe_o), 32'd1);
        check_eq("rd_rwds", 32'({rwds_oe_o, rwds_o}), 32'b110);
        step(1'b0, 1'b1, 16'($urandom), 2'($urandom));
      end else begin
        w = (wq.size() > 0) ? wq.pop_front() : 16'($urandom);
        m = (mq.size() > 0) ? mq.pop_front() : 2'b00;
        check_eq("wr_oe", 32'({dq_oe_o, rwds_oe_o}), 32'd0);
        step(1'b0, 1'b1, w, m);
        if (as) begin
          if (ua[3]) cr0_m = w;
        end else begin
          if (!m[1]) mem_m[a][15:8] = w[15:8];
          if (!m[0]) mem_m[a][7:0]  = w[7:0];
        end
      end
      if (!as) a = nxt(a, lin);
    end
    step(1'b1, 1'b0, 16'($urandom), 2'b00);
    check_eq("end_oe", 32'({dq_oe_o, rwds_oe_o}), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, n;
    bit rd, lin;
    rst_ni = 1'b0; cs_ni = 1'b1; ck_en_i = 1'b0; dq_i = '0; rwds_i = '0;
    repeat (3) step(1'b1, 1'b0, 16'h0000, 2'b00);
    check_eq("rst_dq", 32'(dq_o), 32'd0);
    check_eq("rst_dq_oe", 32'(dq_oe_o), 32'd0);
    check_eq("rst_rwds", 32'(rwds_o), 32'd0);
    check_eq("rst_rwds_oe", 32'(rwds_oe_o), 32'd0);
    @(negedge clk);
    rst_ni = 1'b1;
    cr0_m = 16'h0068;

    // Register reads: ID0 then CR0 at reset latency (12).
    xfer(1'b1, 1'b1, 1'b0, 0, 1, 3);
    xfer(1'b1, 1'b1, 1'b0, 8, 2, 3);

    // Preload whole array with each word's own address, 0x020 cleared.
    for (int i = 0; i < N; i++) begin
      wq.push_back((i == 32) ? 16'h0000 : 16'(i));
      mq.push_back(2'b00);
    end
    xfer(1'b0, 1'b0, 1'b1, 0, N, 3);

    // Wrapped read from 0x01E: 1E, 1F, 10, 11.
    xfer(1'b1, 1'b0, 1'b0, 16'h01E, 4, 3);

    // Linear write/read of four words at 0x010.
    for (int i = 0; i < 4; i++) begin
      wq.push_back(16'h1111 * 16'(i + 1));
      mq.push_back(2'b00);
    end
    xfer(1'b0, 1'b0, 1'b1, 16'h010, 4, 3);
    xfer(1'b1, 1'b0, 1'b1, 16'h010, 4, 3);

    // Low byte masked write over zero: AB00.
    wq.push_back(16'hABCD); mq.push_back(2'b01);
    xfer(1'b0, 1'b0, 1'b1, 16'h020, 1, 3);
    xfer(1'b1, 1'b0, 1'b1, 16'h020, 1, 3);

    // CR0 = 0x0030: latency 3, single; then memory read and CR0 read.
    wq.push_back(16'h0030); mq.push_back(2'b11);
    xfer(1'b0, 1'b1, 1'b0, 8, 1, 3);
    xfer(1'b1, 1'b0, 1'b1, 16'h010, 2, 3);
    xfer(1'b1, 1'b1, 1'b0, 8, 1, 3);

    // Aborted command after two CA words, then a clean read of that range.
    xfer(1'b0, 1'b0, 1'b1, 16'h040, 4, 2);
    xfer(1'b1, 1'b0, 1'b1, 16'h040, 4, 3);

    // Write cut after 2 of 4 words.
    xfer(1'b0, 1'b0, 1'b1, 16'h050, 2, 3);
    xfer(1'b1, 1'b0, 1'b1, 16'h050, 4, 3);

    // Random traffic.
    for (int t = 0; t < 150; t++) begin
      int kind;
      kind = int'($urandom_range(9, 0));
      if (kind == 0) begin
        wq.push_back(16'($urandom)); mq.push_back(2'($urandom));
        xfer(1'b0, 1'b1, 1'b0, ($urandom_range(1, 0) == 1) ? 8 : 0, 1, 3);
      end else if (kind == 1) begin
        xfer(1'b1, 1'b1, 1'b0, ($urandom_range(1, 0) == 1) ? 8 : 0,
             int'($urandom_range(3, 1)), 3);
      end else if (kind == 2) begin
        xfer(1'($urandom), 1'b0, 1'($urandom), int'($urandom_range(N - 1, 0)), 4,
             int'($urandom_range(2, 0)));
      end else begin
        rd  = 1'($urandom);
        lin = 1'($urandom);
        a   = int'($urandom_range(N - 1, 0));
        n   = int'($urandom_range(20, 1));
        if (!rd)
          for (int i = 0; i < n; i++) begin
            wq.push_back(16'($urandom)); mq.push_back(2'($urandom));
          end
        xfer(rd, 1'b0, lin, a, n, 3);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
